sw_req_arbiter: RTL and testbench

SW_REQ_ARBITER -- requirements
Module: sw_req_arbiter

---
 rtl/sw_req_arbiter.sv | 117 +++++++++++
 tb/tb_sw_req_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sw_req_arbiter.sv
// Round-robin arbiter issuing one requester's select/op id to busy-tracked switch instances.
// Optional macro SW_ARB_SEL_CHECK_EN: non-one-hot selects are flagged on err instead of issued.
module sw_req_arbiter #(
  parameter int NUM_SW_INST = 5,
  parameter int NUM_REQ     = 2,
  parameter int W_OP        = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*NUM_SW_INST-1:0] req_sel,
  input  logic [NUM_REQ*W_OP-1:0]        req_op_id,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_SW_INST-1:0]         sw_busy,
  output logic [NUM_SW_INST-1:0]         sel_en,
  output logic [W_OP-1:0]                op_id_out,
  output logic                           err
);

  localparam int PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e                 state_q, state_d;
  logic [PtrW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_SW_INST-1:0] sel_en_q, sel_en_d;
  logic [W_OP-1:0]        op_id_q, op_id_d;
  logic                   err_q, err_d;

  logic [NUM_REQ-1:0]     eligible;
  logic                   grant;
  logic [PtrW-1:0]        win_idx;
  logic [NUM_SW_INST-1:0] win_sel;
  logic [W_OP-1:0]        win_op;

  always_comb begin
    logic [NUM_SW_INST-1:0] sel_i;
    sel_i    = '0;
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_i = req_sel[i*NUM_SW_INST +: NUM_SW_INST];
`ifdef SW_ARB_SEL_CHECK_EN
      // Illegal selects never wait on busy: they only produce an err pulse.
      eligible[i] = req_valid[i] && (!$onehot(sel_i) || ((sel_i & sw_busy) == '0));
`else
      eligible[i] = req_valid[i] && ((sel_i & sw_busy) == '0);
`endif
    end
  end

  // Search upward from rr_ptr, wrapping, and take the first eligible requester.
  always_comb begin
    int idx;
    idx     = 0;
    grant   = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant && eligible[idx]) begin
        grant   = 1'b1;
        win_idx = PtrW'(idx);
      end
    end
  end

  assign win_sel = req_sel[int'(win_idx)*NUM_SW_INST +: NUM_SW_INST];
  assign win_op  = req_op_id[int'(win_idx)*W_OP +: W_OP];

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    sel_en_d  = '0;
    op_id_d   = op_id_q;
    err_d     = 1'b0;
    req_ready = '0;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          req_ready[win_idx] = 1'b1;
          state_d            = StIssue;
          rr_ptr_d           = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + PtrW'(1);
          op_id_d            = win_op;
`ifdef SW_ARB_SEL_CHECK_EN
          if ($onehot(win_sel)) sel_en_d = win_sel;
          else                  err_d    = 1'b1;
`else
          sel_en_d = win_sel;
`endif
        end
      end
      StIssue: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      sel_en_q <= '0;
      op_id_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sel_en_q <= sel_en_d;
      op_id_q  <= op_id_d;
      err_q    <= err_d;
    end
  end

  assign sel_en    = sel_en_q;
  assign op_id_out = op_id_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sw_req_arbiter.sv
// Directed self-checking bench for sw_req_arbiter (NUM_REQ=2, NUM_SW_INST=5, W_OP=8).
module tb_sw_req_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [9:0] req_sel;
  logic [15:0] req_op_id;
  logic [1:0] req_ready;
  logic [4:0] sw_busy;
  logic [4:0] sel_en;
  logic [7:0] op_id_out;
  logic       err;

  int n_checks;
  int n_fail;

  sw_req_arbiter #(
    .NUM_SW_INST(5),
    .NUM_REQ    (2),
    .W_OP       (8)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_sel  (req_sel),
    .req_op_id(req_op_id),
    .req_ready(req_ready),
    .sw_busy  (sw_busy),
    .sel_en   (sel_en),
    .op_id_out(op_id_out),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reset mid-cycle, check reset values, release away from the clock edge.
  task automatic reset_dut();
    next_cycle();
    rst_n     = 1'b0;
    req_valid = '0;
    req_sel   = '0;
    req_op_id = '0;
    sw_busy   = '0;
    #2;
    check_val("rst_sel_en", 32'(sel_en), 32'h0);
    check_val("rst_op_id", 32'(op_id_out), 32'h0);
    check_val("rst_err", 32'(err), 32'h0);
    check_val("rst_ready", 32'(req_ready), 32'h0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] exp_rdy [8];
    logic [4:0] exp_sel [8];
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_sel   = '0;
    req_op_id = '0;
    sw_busy   = '0;

    // Single request: ready in t, strobe in t+1, quiet in t+2.
    reset_dut();
    req_valid = 2'b01;
    req_sel   = {5'b0, 5'b00001};
    req_op_id = {8'h00, 8'h11};
    @(negedge clk);
    check_val("t1_ready_t", 32'(req_ready), 32'h1);
    check_val("t1_sel_en_t", 32'(sel_en), 32'h0);
    next_cycle();
    req_valid = 2'b00;
    @(negedge clk);
    check_val("t1_sel_en_t1", 32'(sel_en), 32'h01);
    check_val("t1_op_t1", 32'(op_id_out), 32'h11);
    check_val("t1_ready_t1", 32'(req_ready), 32'h0);
    next_cycle();
    @(negedge clk);
    check_val("t1_sel_en_t2", 32'(sel_en), 32'h0);
    check_val("t1_op_hold", 32'(op_id_out), 32'h11);

    // Two held requesters alternate every two cycles.
    reset_dut();
    req_valid = 2'b11;
    req_sel   = {5'b00100, 5'b00010};
    req_op_id = {8'h21, 8'h20};
    exp_rdy = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
    exp_sel = '{5'b0, 5'b00010, 5'b0, 5'b00100, 5'b0, 5'b00010, 5'b0, 5'b0};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_val($sformatf("t2_ready_c%0d", c), 32'(req_ready), 32'(exp_rdy[c]));
      check_val($sformatf("t2_sel_en_c%0d", c), 32'(sel_en), 32'(exp_sel[c]));
      if (c == 3) check_val("t2_op_c3", 32'(op_id_out), 32'h21);
      next_cycle();
    end

    // Busy target waits; other requester goes first; busy drop grants in the same cycle.
    reset_dut();
    req_valid = 2'b11;
    req_sel   = {5'b00001, 5'b01000};
    req_op_id = {8'h31, 8'h30};
    sw_busy   = 5'b01000;
    exp_rdy = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
    exp_sel = '{5'b0, 5'b00001, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b01000};
    for (int c = 0; c < 8; c++) begin
      sw_busy = (c < 6) ? 5'b01000 : 5'b00000;
      @(negedge clk);
      check_val($sformatf("t3_ready_c%0d", c), 32'(req_ready), 32'(exp_rdy[c]));
      check_val($sformatf("t3_sel_en_c%0d", c), 32'(sel_en), 32'(exp_sel[c]));
      next_cycle();
      req_valid = req_valid & ~exp_rdy[c];
    end
    check_val("t3_op_last", 32'(op_id_out), 32'h30);

    // Reset during ISSUE suppresses the strobe and returns to IDLE.
    reset_dut();
    req_valid = 2'b01;
    req_sel   = {5'b0, 5'b00100};
    req_op_id = {8'h00, 8'hA5};
    @(negedge clk);
    check_val("t4_ready", 32'(req_ready), 32'h1);
    next_cycle();
    rst_n     = 1'b0;
    req_valid = 2'b00;
    #1;
    check_val("t4_sel_en_rst", 32'(sel_en), 32'h0);
    check_val("t4_op_rst", 32'(op_id_out), 32'h0);
    #2;
    rst_n = 1'b1;
    next_cycle();
    check_val("t4_sel_en_after", 32'(sel_en), 32'h0);
    req_valid = 2'b10;
    req_sel   = {5'b00001, 5'b0};
    req_op_id = {8'h44, 8'h00};
    @(negedge clk);
    check_val("t4_idle_grant", 32'(req_ready), 32'h2);
    next_cycle();
    req_valid = 2'b00;
    @(negedge clk);
    check_val("t4_sel_en_new", 32'(sel_en), 32'h01);
    check_val("t4_op_new", 32'(op_id_out), 32'h44);

    // Multi-hot select: flagged with the check macro, broadcast without it.
    reset_dut();
    req_valid = 2'b01;
    req_sel   = {5'b0, 5'b00011};
    req_op_id = {8'h00, 8'h22};
    @(negedge clk);
    check_val("t5_ready", 32'(req_ready), 32'h1);
    next_cycle();
    req_valid = 2'b00;
    @(negedge clk);
`ifdef SW_ARB_SEL_CHECK_EN
    check_val("t5_sel_en", 32'(sel_en), 32'h0);
    check_val("t5_err", 32'(err), 32'h1);
`else
    check_val("t5_sel_en", 32'(sel_en), 32'h03);
    check_val("t5_err", 32'(err), 32'h0);
`endif
    next_cycle();
    @(negedge clk);
    check_val("t5_err_after", 32'(err), 32'h0);
    check_val("t5_sel_en_after", 32'(sel_en), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
